// File: rtl/edge_job_scheduler_pkg.sv
// edge_sched_pkg: shared FSM states, status bit positions and default sizing for the edge job scheduler
package edge_sched_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, DONE, ERROR} state_e;
  localparam int ST_TIMEOUT = 0;
  localparam int ST_SHORT = 1;
  localparam int ST_OVF = 2;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_LINES = 62;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_FIFO_DEPTH = 2;
endpackage

// File: rtl/edge_job_scheduler_if.sv
// edge_sched_if: host, coprocessor, result RAM and VGA arbitration signals of the edge job scheduler
interface edge_sched_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
);
  logic              host_start;
  logic [ADDR_W-1:0] host_addr_in;
  logic [ADDR_W-1:0] host_addr_out;
  logic              host_clear;
  logic              host_ready;
  logic              host_busy;
  logic              host_done;
  logic [2:0]        host_status;
  logic              cop_start;
  logic [ADDR_W-1:0] cop_address_base;
  logic [ADDR_W-1:0] cop_address_out;
  logic              cop_line;
  logic [DATA_W-1:0] cop_pixel;
  logic              cop_done;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              vga_req;
  logic              vga_grant;
  modport master (
    output host_start, host_addr_in, host_addr_out, host_clear, cop_line, cop_pixel, cop_done, vga_req,
    input  host_ready, host_busy, host_done, host_status, cop_start, cop_address_base, cop_address_out,
           wr_en, wr_addr, wr_data, vga_grant
  );
  modport slave (
    input  host_start, host_addr_in, host_addr_out, host_clear, cop_line, cop_pixel, cop_done, vga_req,
    output host_ready, host_busy, host_done, host_status, cop_start, cop_address_base, cop_address_out,
           wr_en, wr_addr, wr_data, vga_grant
  );
endinterface

// File: rtl/edge_job_scheduler_fifo.sv
// edge_line_fifo: small line holding FIFO; a push into a full FIFO lands only when a pop happens the same cycle
module edge_line_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic wr;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty = wp_q == rp_q;
  assign dout = mem_q[rp_q[AW-1:0]];
  assign wr = push && (!full || pop);
  // pointer update; flush discards every held line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (pop && !empty) rp_q <= rp_q + 1'b1;
    end
  // line storage; the slot being popped may be overwritten in the same cycle
  always_ff @(posedge clk)
    if (wr && !flush) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/edge_job_scheduler.sv
// edge_job_scheduler: queues host jobs, launches the coprocessor and streams its lines into the shared result RAM
module edge_job_scheduler
  import edge_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LINES_PER_FRAME = DEF_LINES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic        clk_50M,
  input logic        reset,
  edge_sched_if.slave bus
);
  localparam int CW = $clog2(LINES_PER_FRAME + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LPF = CW'(LINES_PER_FRAME);
  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT_CYCLES - 1);
  state_e state_q, state_d;
  logic slot_full_q;
  logic [ADDR_W-1:0] slot_src_q, slot_dst_q, base_q, out_q, wr_ptr_q;
  logic [CW-1:0] line_cnt_q;
  logic [TW-1:0] wd_q;
  logic [2:0] status_q, status_set;
  logic line_in, line_full, fifo_push, pop, flush, fifo_full, fifo_empty, launch;
  logic [DATA_W-1:0] fifo_head;
  assign line_in = state_q == RUN && bus.cop_line;
  assign line_full = line_cnt_q == LPF;
  assign fifo_push = line_in && !line_full;
  assign flush = state_q == ERROR && bus.host_clear;
  assign launch = state_d == LAUNCH;
  assign bus.host_ready = !slot_full_q;
  assign bus.host_status = status_q;
  assign bus.cop_address_base = base_q;
  assign bus.cop_address_out = out_q;
  edge_line_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_50M), .rst_n(reset), .push(fifo_push), .pop(pop), .flush(flush),
    .din(bus.cop_pixel), .dout(fifo_head), .full(fifo_full), .empty(fifo_empty)
  );
  // state register
  always_ff @(posedge clk_50M or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic; cop_done outranks the watchdog, and a line in the same cycle restarts it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = slot_full_q ? LAUNCH : IDLE;
      LAUNCH:  state_d = RUN;
      RUN:     state_d = bus.cop_done ? DRAIN : (!bus.cop_line && wd_q == WD_MAX) ? ERROR : RUN;
      DRAIN:   state_d = fifo_empty ? DONE : DRAIN;
      DONE:    state_d = slot_full_q ? LAUNCH : IDLE;
      ERROR:   state_d = bus.host_clear ? IDLE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  // FSM outputs
  always_comb begin
    bus.cop_start = state_q == LAUNCH;
    bus.host_done = state_q == DONE;
    bus.host_busy = state_q != IDLE;
  end
  // RAM port arbiter: a full FIFO must drain, otherwise VGA has priority over the writer
  always_comb begin
    pop = fifo_full || (!bus.vga_req && !fifo_empty);
    bus.vga_grant = !fifo_full && bus.vga_req;
    bus.wr_en = pop;
    bus.wr_addr = wr_ptr_q;
    bus.wr_data = pop ? fifo_head : '0;
  end
  // sticky status events raised this cycle
  always_comb begin
    status_set = '0;
    status_set[ST_TIMEOUT] = state_q == RUN && state_d == ERROR;
    status_set[ST_SHORT] = state_q == DRAIN && fifo_empty && !line_full;
    status_set[ST_OVF] = (line_in && line_full) || (fifo_push && fifo_full && !pop);
  end
  // job slot, per-job datapath registers, watchdog and status
  always_ff @(posedge clk_50M or negedge reset)
    if (!reset) begin
      slot_full_q <= 1'b0;
      slot_src_q <= '0;
      slot_dst_q <= '0;
      base_q <= '0;
      out_q <= '0;
      wr_ptr_q <= '0;
      line_cnt_q <= '0;
      wd_q <= '0;
      status_q <= '0;
    end else begin
      if (bus.host_start && !slot_full_q) begin
        slot_full_q <= 1'b1;
        slot_src_q <= bus.host_addr_in;
        slot_dst_q <= bus.host_addr_out;
      end else if (launch) slot_full_q <= 1'b0;
      if (launch) begin
        base_q <= slot_src_q;
        out_q <= slot_dst_q;
        wr_ptr_q <= slot_dst_q;
        line_cnt_q <= '0;
        wd_q <= '0;
      end else begin
        if (pop) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fifo_push) line_cnt_q <= line_cnt_q + 1'b1;
        if (state_q == RUN) wd_q <= bus.cop_line ? '0 : wd_q + 1'b1;
      end
      status_q <= bus.host_clear ? '0 : status_q | status_set;
    end
endmodule

// File: tb/tb_edge_job_scheduler.sv
// tb_edge_job_scheduler: directed jobs with a write scoreboard checked by an independent RAM-port monitor
module tb_edge_job_scheduler;
  localparam int AW = 12;
  localparam int DW = 64;
  logic clk_50M = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [AW-1:0] exp_addr;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  always #10 clk_50M = ~clk_50M;
  edge_sched_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
  edge_job_scheduler dut (.clk_50M(clk_50M), .reset(reset), .bus(ifc));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  // monitor: every RAM write must match the oldest expected write
  always @(negedge clk_50M)
    if (reset) begin
      if (ifc.host_done) done_cnt++;
      if (ifc.vga_grant) chk("grant_excl", 64'(ifc.wr_en), 64'd0);
      if (ifc.wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected addr=%h data=%h", ifc.wr_addr, ifc.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 64'(ifc.wr_addr), 64'(mon_e[AW+DW-1:DW]));
          chk("wr_data", ifc.wr_data, mon_e[DW-1:0]);
        end
      end
    end
  task automatic tick;
    @(posedge clk_50M);
    #1;
  endtask
  task automatic start_job(input logic [AW-1:0] src, input logic [AW-1:0] dst);
    ifc.host_addr_in = src;
    ifc.host_addr_out = dst;
    ifc.host_start = 1'b1;
    tick;
    ifc.host_start = 1'b0;
  endtask
  task automatic send_line(input logic [DW-1:0] d, input bit expect_wr);
    ifc.cop_line = 1'b1;
    ifc.cop_pixel = d;
    if (expect_wr) begin
      exp_q.push_back({exp_addr, d});
      exp_addr++;
    end
    tick;
    ifc.cop_line = 1'b0;
  endtask
  task automatic lines(input int n, input int gap, input int keep, input int tag);
    for (int i = 0; i < n; i++) begin
      send_line({32'hDA7A0000 + 32'(tag), 32'(i) * 32'h01010101}, i < keep);
      repeat (gap) tick;
    end
  endtask
  task automatic finish_job(input string nm);
    int d0;
    d0 = done_cnt;
    ifc.cop_done = 1'b1;
    tick;
    ifc.cop_done = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) tick;
    chk(nm, 64'(done_cnt - d0), 64'd1);
  endtask
  task automatic do_reset;
    reset = 1'b0;
    repeat (2) tick;
    reset = 1'b1;
    tick;
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, 64'(ifc.host_ready), 64'd1);
    chk({nm, "_busy"}, 64'(ifc.host_busy), 64'd0);
    chk({nm, "_done"}, 64'(ifc.host_done), 64'd0);
    chk({nm, "_status"}, 64'(ifc.host_status), 64'd0);
    chk({nm, "_cop_start"}, 64'(ifc.cop_start), 64'd0);
    chk({nm, "_base"}, 64'(ifc.cop_address_base), 64'd0);
    chk({nm, "_out"}, 64'(ifc.cop_address_out), 64'd0);
    chk({nm, "_wr_en"}, 64'(ifc.wr_en), 64'd0);
    chk({nm, "_wr_addr"}, 64'(ifc.wr_addr), 64'd0);
    chk({nm, "_wr_data"}, ifc.wr_data, 64'd0);
    chk({nm, "_grant"}, 64'(ifc.vga_grant), 64'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    ifc.host_start = 0; ifc.host_addr_in = '0; ifc.host_addr_out = '0; ifc.host_clear = 0;
    ifc.cop_line = 0; ifc.cop_pixel = '0; ifc.cop_done = 0; ifc.vga_req = 0;
    repeat (3) tick;
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick;
    // single job, VGA idle
    start_job(12'h010, 12'h100);
    chk("t1_ready_low", 64'(ifc.host_ready), 64'd0);
    chk("t1_no_start_yet", 64'(ifc.cop_start), 64'd0);
    tick;
    chk("t1_cop_start", 64'(ifc.cop_start), 64'd1);
    chk("t1_base", 64'(ifc.cop_address_base), 64'h010);
    chk("t1_out", 64'(ifc.cop_address_out), 64'h100);
    chk("t1_busy", 64'(ifc.host_busy), 64'd1);
    tick;
    exp_addr = 12'h100;
    lines(62, 1, 62, 1);
    finish_job("t1_done_once");
    chk("t1_status", 64'(ifc.host_status), 64'd0);
    tick;
    chk("t1_idle", 64'(ifc.host_busy), 64'd0);
    // VGA holds the port, FIFO fills and the writer takes over
    start_job(12'h020, 12'h200);
    ifc.vga_req = 1'b1;
    tick;
    tick;
    exp_addr = 12'h200;
    for (int i = 0; i < 62; i++) begin
      send_line({32'hDA7A0002, 32'(i) * 32'h01010101}, 1'b1);
      if (i == 0) chk("t2_grant_vga", 64'(ifc.vga_grant), 64'd1);
      if (i == 1 || i == 2) begin
        chk("t2_full_no_grant", 64'(ifc.vga_grant), 64'd0);
        chk("t2_full_write", 64'(ifc.wr_en), 64'd1);
      end
      repeat (3) tick;
    end
    ifc.vga_req = 1'b0;
    finish_job("t2_done");
    chk("t2_status", 64'(ifc.host_status), 64'd0);
    // second job queued while the first runs
    start_job(12'h030, 12'h300);
    tick;
    tick;
    exp_addr = 12'h300;
    lines(10, 0, 10, 3);
    start_job(12'h0AA, 12'h400);
    chk("t3_ready_drop", 64'(ifc.host_ready), 64'd0);
    lines(52, 0, 52, 4);
    ifc.cop_done = 1'b1;
    tick;
    ifc.cop_done = 1'b0;
    for (int i = 0; i < 200 && !ifc.host_done; i++) tick;
    chk("t3_done_seen", 64'(ifc.host_done), 64'd1);
    tick;
    chk("t3_relaunch", 64'(ifc.cop_start), 64'd1);
    chk("t3_base", 64'(ifc.cop_address_base), 64'h0AA);
    chk("t3_out", 64'(ifc.cop_address_out), 64'h400);
    tick;
    exp_addr = 12'h400;
    lines(62, 0, 62, 5);
    finish_job("t3_done_b");
    chk("t3_status", 64'(ifc.host_status), 64'd0);
    // short frame, then overflow
    do_reset;
    start_job(12'h040, 12'h500);
    tick;
    tick;
    exp_addr = 12'h500;
    lines(60, 1, 60, 6);
    finish_job("t4_short_done");
    chk("t4_short", 64'(ifc.host_status), 64'b010);
    start_job(12'h050, 12'h600);
    tick;
    tick;
    exp_addr = 12'h600;
    lines(63, 1, 62, 7);
    finish_job("t4_ovf_done");
    chk("t4_ovf", 64'(ifc.host_status), 64'b110);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);
    // watchdog timeout and recovery
    do_reset;
    start_job(12'h060, 12'h700);
    for (int i = 0; i < 5000 && !ifc.host_status[0]; i++) tick;
    chk("t5_status", 64'(ifc.host_status), 64'b001);
    chk("t5_busy", 64'(ifc.host_busy), 64'd1);
    send_line(64'hDEAD_BEEF_0000_0001, 1'b0);
    ifc.cop_done = 1'b1;
    tick;
    ifc.cop_done = 1'b0;
    repeat (3) tick;
    chk("t5_stuck", 64'(ifc.host_busy), 64'd1);
    ifc.host_clear = 1'b1;
    tick;
    ifc.host_clear = 1'b0;
    chk("t5_clear_busy", 64'(ifc.host_busy), 64'd0);
    chk("t5_clear_status", 64'(ifc.host_status), 64'd0);
    chk("t5_clear_ready", 64'(ifc.host_ready), 64'd1);
    // address wrap, then reset mid-job
    do_reset;
    start_job(12'h070, 12'hFFE);
    tick;
    tick;
    exp_addr = 12'hFFE;
    lines(4, 1, 4, 8);
    chk("t6_wrap_ptr", 64'(ifc.wr_addr), 64'h002);
    finish_job("t6_wrap_done");
    start_job(12'h080, 12'h800);
    tick;
    tick;
    ifc.vga_req = 1'b1;
    send_line(64'h1234_5678_9ABC_DEF0, 1'b0);
    chk("t6_held", 64'(ifc.wr_en), 64'd0);
    reset = 1'b0;
    ifc.vga_req = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    tick;
    chk_reset_outputs("t6_edge");
    reset = 1'b1;
    repeat (5) tick;
    chk("t6_no_start", 64'(ifc.cop_start), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
